fuzzifier_lut: RTL and testbench
================================

Name: fuzzifier_lut

Overview:
- Parametrised, run-time-loadable successor to the single fixed membership ROM.
- Holds NF membership-function tables of 2^AW entries, each DW bits wide.
- For each accepted crisp input sample x, it emits NF membership degrees mu_k(x) serially over a valid/ready stream.
- Sits between the feature quantiser and the fuzzy rule-evaluation stage of the speech-processing datapath.

Parameters:
- AW, 8, input/address width; each table has 2^AW entries.
- DW, 8, membership degree width.
- NF, 4, number of membership functions (channels), NF >= 2.
- SW, 2, select width, equal to ceil(log2(NF)).
- DEF, 2, value written to entries 1..2^AW-1 of every table during init; entry 0 is always written 0.

Ports:
- CS  input  1  clock; all logic on rising edge.
- cen  input  1  synchronous active-high reset.
- wr_en  input  1  table write strobe.
- wr_sel  input  SW  table index for the write.
- wr_addr  input  AW  entry address for the write.
- wr_data  input  DW  value to write.
- in_valid  input  1  input sample valid.
- in_ready  output  1  block can accept a sample.
- in_x  input  AW  crisp input sample.
- out_valid  output  1  out_mu/out_sel valid.
- out_ready  input  1  downstream accepts the output.
- out_sel  output  SW  membership-function index of out_mu.
- out_mu  output  DW  membership degree TABLE[out_sel][x].
- out_last  output  1  marks the final degree (out_sel == NF-1) of the current sample.
- init_busy  output  1  table initialisation in progress.

Behaviour:
- Reset: cen=1 sampled at a rising edge sets the state to INIT and clears the init counter to 0.
  - Register values while cen=1: in_ready=0, out_valid=0, out_sel=0, out_mu=0, out_last=0, init_busy=1.
  - Reset overrides every other event. Reset mid-sample drops the sample with no partial output, and initialisation restarts from address 0.
- States: INIT, IDLE, EMIT.
- INIT:
  - Each cycle, entry[cnt] of all NF tables is written in parallel: 0 if cnt==0, else DEF.
  - cnt increments by 1 per cycle. After writing cnt == 2^AW-1, the state moves to IDLE.
  - init_busy=1 for exactly 2^AW cycles after reset release.
  - wr_en is ignored during INIT. in_ready=0.
- IDLE:
  - in_ready=1 and out_valid=0.
  - When in_valid&&in_ready at edge t: latch x=in_x and enter EMIT.
  - At edge t: out_mu<=TABLE[0][x], out_sel<=0, out_valid<=1. The first degree is therefore visible in the cycle after acceptance (latency 1).
- EMIT:
  - in_ready=0.
  - If out_valid && !out_ready: out_mu, out_sel and out_last hold stable.
  - On a handshake with out_sel=k<NF-1: out_mu<=TABLE[k+1][x] and out_sel<=k+1 at the same edge. This gives one degree per cycle under continuous out_ready.
  - out_last = (out_sel == NF-1).
  - On a handshake with out_last=1: out_valid<=0, out_last<=0, return to IDLE. in_ready=1 in the following cycle.
  - Minimum sample period is NF+1 cycles.
- Writes:
  - Outside INIT, wr_en=1 writes TABLE[wr_sel][wr_addr]<=wr_data at the edge.
  - Writes are allowed in IDLE and EMIT.
  - wr_sel >= NF: the write is ignored.
- Read/write collision: a write at the same edge that loads out_mu from the same table and entry makes out_mu take the OLD value (read-before-write). The new value is seen by later reads.
- No arithmetic on data; values pass through unmodified.
- The table is latched x, not live in_x; in_x changes during EMIT have no effect.

Test Plan:
- Hold cen=1 for 3 cycles, then release -> init_busy=1 for exactly 256 cycles with in_ready=0; then in_ready=1 and init_busy=0.
- After init, send x=0 with out_ready=1 -> four cycles: out_sel 0,1,2,3, all out_mu=0x00, out_last only on out_sel=3. Then send x=5 -> out_mu=0x02 on all four.
- Write TABLE[2][0x40]=0xA5 and TABLE[0][0x40]=0x11, then send x=0x40 -> out_mu sequence 0x11, 0x02, 0xA5, 0x02. A write with wr_sel=3 must land in table 3; wr_en pulses during INIT must leave tables at their default values.
- With x=0x40 active and out_ready toggled 1,0,0,1,... -> out_mu/out_sel stable while stalled, no degree skipped or repeated, in_ready=0 until the final handshake.
- Collision: at the edge loading out_sel=2 for x=0x40, write TABLE[2][0x40]=0x7E -> out_mu=0xA5 (old value). The next sample with x=0x40 gives 0x7E.
- Assert cen during EMIT at out_sel=1 -> outputs cleared next cycle, INIT re-runs for 256 cycles, and table 2 entry 0x40 reads back 0x02 afterwards.

Source files
------------

// File: rtl/fuzzifier_lut.sv
// Run-time loadable fuzzifier: NF membership tables of 2^AW entries, degrees
// of one crisp sample are streamed out serially, one table per handshake.
//
//   state  | meaning
//   S_INIT | fill entry r_cnt of all tables with 0 (entry 0) or DEF
//   S_IDLE | waiting for an input sample, in_ready=1
//   S_EMIT | streaming TABLE[0..NF-1][x] on the output port
module fuzzifier_lut #(
    parameter int AW  = 8,
    parameter int DW  = 8,
    parameter int NF  = 4,
    parameter int SW  = 2,
    parameter int DEF = 2
) (
    input  logic          CS,
    input  logic          cen,
    input  logic          wr_en,
    input  logic [SW-1:0] wr_sel,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [AW-1:0] in_x,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [SW-1:0] out_sel,
    output logic [DW-1:0] out_mu,
    output logic          out_last,
    output logic          init_busy
);

    typedef enum logic [1:0] {
        S_INIT = 2'd0,
        S_IDLE = 2'd1,
        S_EMIT = 2'd2
    } state_t;

    localparam logic [SW-1:0] LAST_SEL = SW'(NF - 1);
    localparam logic [SW:0]   NF_W     = (SW + 1)'(NF);
    localparam logic [DW-1:0] DEF_W    = DW'(DEF);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [AW-1:0] r_cnt;
    logic [AW-1:0] r_x;
    logic [DW-1:0] r_tab [NF][2**AW];
    logic [SW-1:0] r_out_sel;
    logic [DW-1:0] r_out_mu;
    logic          r_out_valid;
    logic          r_out_last;

    logic          w_accept;
    logic          w_out_hs;
    logic          w_wr_ok;
    logic [SW-1:0] w_sel_nxt;

    assign w_accept  = (r_state == S_IDLE) && in_valid;
    assign w_out_hs  = r_out_valid && out_ready;
    assign w_sel_nxt = r_out_sel + SW'(1);
    assign w_wr_ok   = wr_en && (r_state != S_INIT) && ({1'b0, wr_sel} < NF_W);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_INIT:  if (r_cnt == '1) w_state_nxt = S_IDLE;
            S_IDLE:  if (w_accept) w_state_nxt = S_EMIT;
            S_EMIT:  if (w_out_hs && r_out_last) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_INIT;
        endcase
    end

    always_ff @(posedge CS) begin
        if (cen) r_state <= S_INIT;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge CS) begin
        if (cen)                   r_cnt <= '0;
        else if (r_state == S_INIT) r_cnt <= r_cnt + AW'(1);
    end

    // Table reads use the pre-edge contents, so a same-edge write is seen
    // only by later reads.
    always_ff @(posedge CS) begin
        if (cen) begin
            r_out_valid <= 1'b0;
            r_out_sel   <= '0;
            r_out_mu    <= '0;
            r_out_last  <= 1'b0;
            r_x         <= '0;
        end else if (w_accept) begin
            r_x         <= in_x;
            r_out_mu    <= r_tab[0][in_x];
            r_out_sel   <= '0;
            r_out_valid <= 1'b1;
            r_out_last  <= 1'b0;
        end else if ((r_state == S_EMIT) && w_out_hs) begin
            if (r_out_last) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end else begin
                r_out_sel  <= w_sel_nxt;
                r_out_mu   <= r_tab[w_sel_nxt][r_x];
                r_out_last <= (w_sel_nxt == LAST_SEL);
            end
        end
    end

    always_ff @(posedge CS) begin
        if (!cen) begin
            if (r_state == S_INIT) begin
                for (int k = 0; k < NF; k++)
                    r_tab[k][r_cnt] <= (r_cnt == '0) ? '0 : DEF_W;
            end else if (w_wr_ok) begin
                r_tab[wr_sel][wr_addr] <= wr_data;
            end
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign init_busy = (r_state == S_INIT);
    assign out_valid = r_out_valid;
    assign out_sel   = r_out_sel;
    assign out_mu    = r_out_mu;
    assign out_last  = r_out_last;

endmodule

// File: tb/tb_fuzzifier_lut.sv
// Bench for fuzzifier_lut: cycle-level reference model of the tables and the
// serial emission, directed scenarios with literal expectations, then random traffic.
module tb_fuzzifier_lut;
    localparam int AW  = 8;
    localparam int DW  = 8;
    localparam int NF  = 4;
    localparam int SW  = 2;
    localparam int DEF = 2;
    localparam int NE  = 1 << AW;

    logic          CS = 1'b0;
    logic          cen = 1'b1;
    logic          wr_en = 1'b0;
    logic [SW-1:0] wr_sel = '0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [AW-1:0] in_x = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [SW-1:0] out_sel;
    logic [DW-1:0] out_mu;
    logic          out_last;
    logic          init_busy;

    int n_tests = 0;
    int n_fail  = 0;

    fuzzifier_lut #(.AW(AW), .DW(DW), .NF(NF), .SW(SW), .DEF(DEF)) dut (
        .CS(CS), .cen(cen), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
        .wr_data(wr_data), .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
        .out_valid(out_valid), .out_ready(out_ready), .out_sel(out_sel),
        .out_mu(out_mu), .out_last(out_last), .init_busy(init_busy)
    );

    always #5 CS = ~CS;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tables as a plain array, a sample as "current degree index".
    int mt [NF][NE];
    bit m_started = 0;
    bit m_init = 0;
    int m_cnt = 0;
    bit m_emit = 0;
    int m_x = 0;
    int m_k = 0;
    int m_mu = 0;

    always @(posedge CS) begin
        if (cen) begin
            m_started = 1; m_init = 1; m_cnt = 0; m_emit = 0; m_k = 0; m_mu = 0;
        end else if (m_started && m_init) begin
            for (int k = 0; k < NF; k++) mt[k][m_cnt] = (m_cnt == 0) ? 0 : DEF;
            if (m_cnt == NE - 1) m_init = 0;
            m_cnt++;
        end else if (m_started) begin
            if (!m_emit && in_valid) begin
                m_x = int'(in_x); m_emit = 1; m_k = 0; m_mu = mt[0][m_x];
            end else if (m_emit && out_ready) begin
                if (m_k == NF - 1) m_emit = 0;
                else begin m_k++; m_mu = mt[m_k][m_x]; end
            end
            if (wr_en && int'(wr_sel) < NF) mt[wr_sel][wr_addr] = int'(wr_data);
        end
    end

    always @(negedge CS) begin
        if (m_started) begin
            chk("init_busy", int'(init_busy), int'(m_init));
            chk("in_ready", int'(in_ready), int'(!m_init && !m_emit));
            chk("out_valid", int'(out_valid), int'(m_emit));
            if (m_emit) begin
                chk("out_sel", int'(out_sel), m_k);
                chk("out_mu", int'(out_mu), m_mu);
                chk("out_last", int'(out_last), int'(m_k == NF - 1));
            end
        end
    end

    task automatic tick();
        @(negedge CS);
    endtask

    // Release reset and measure how long init_busy stays high.
    task automatic run_init(input bit pulse_writes);
        int cnt = 0;
        cen = 1'b0;
        while (init_busy && cnt < 400) begin
            if (pulse_writes) begin
                wr_en = 1'($urandom_range(0, 1)); wr_sel = 2'd2;
                wr_addr = (cnt % 3 == 0) ? 8'h40 : AW'($urandom);
                wr_data = 8'hFF;
            end
            cnt++;
            tick();
        end
        wr_en = 1'b0;
        chk("init_len", cnt, NE);
        chk("post_init_ready", int'(in_ready), 1);
    endtask

    // Send one sample, then collect its degrees under an out_ready pattern.
    // When coll is set, a write to TABLE[2][x] coincides with loading degree 2.
    task automatic run_sample(input logic [AW-1:0] x, input logic [3:0] rdy_pat,
                              input bit coll, input logic [DW-1:0] coll_d,
                              output logic [DW-1:0] mus [NF], output int got);
        int guard = 0;
        int cyc = 0;
        got = 0;
        for (int k = 0; k < NF; k++) mus[k] = '0;
        in_x = x; in_valid = 1'b1;
        while (!in_ready && guard < 50) begin guard++; tick(); end
        tick();
        in_valid = 1'b0;
        while (got < NF && cyc < 60) begin
            in_x = AW'($urandom);
            out_ready = rdy_pat[cyc % 4];
            wr_en = 1'b0;
            if (out_valid && out_ready) begin
                if (coll && out_sel == 2'd1) begin
                    wr_en = 1'b1; wr_sel = 2'd2; wr_addr = x; wr_data = coll_d;
                end
                if (got < NF - 1) chk("stall_in_ready", int'(in_ready), 0);
                mus[got] = out_mu;
                chk("sel_order", int'(out_sel), got);
                got++;
            end
            cyc++;
            tick();
        end
        wr_en = 1'b0; out_ready = 1'b0;
        chk("sample_degrees", got, NF);
    endtask

    task automatic expect_mus(input string name, input logic [DW-1:0] mus [NF],
                              input logic [31:0] exp);
        for (int k = 0; k < NF; k++)
            chk(name, int'(mus[k]), int'(exp[8*(NF-1-k) +: 8]));
    endtask

    task automatic host_write(input int sel, input int addr, input int data);
        wr_en = 1'b1; wr_sel = SW'(sel); wr_addr = AW'(addr); wr_data = DW'(data);
        tick();
        wr_en = 1'b0;
    endtask

    logic [DW-1:0] mus [NF];
    int got;

    initial begin
        tick(); tick(); tick();
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_sel", int'(out_sel), 0);
        chk("rst_out_mu", int'(out_mu), 0);
        chk("rst_out_last", int'(out_last), 0);
        chk("rst_init_busy", int'(init_busy), 1);
        run_init(1'b1);

        run_sample(8'h00, 4'hF, 0, '0, mus, got);
        expect_mus("x00", mus, 32'h00000000);
        run_sample(8'h05, 4'hF, 0, '0, mus, got);
        expect_mus("x05", mus, 32'h02020202);
        run_sample(8'h40, 4'hF, 0, '0, mus, got);
        expect_mus("x40_default", mus, 32'h02020202);

        host_write(2, 8'h40, 8'hA5);
        host_write(0, 8'h40, 8'h11);
        host_write(3, 8'h41, 8'h33);
        run_sample(8'h40, 4'hF, 0, '0, mus, got);
        expect_mus("x40_written", mus, 32'h11_02_A5_02);
        run_sample(8'h41, 4'hF, 0, '0, mus, got);
        expect_mus("x41_tab3", mus, 32'h02_02_02_33);
        run_sample(8'h40, 4'b1001, 0, '0, mus, got);
        expect_mus("x40_stall", mus, 32'h11_02_A5_02);

        run_sample(8'h40, 4'hF, 1, 8'h7E, mus, got);
        expect_mus("collision_old", mus, 32'h11_02_A5_02);
        run_sample(8'h40, 4'hF, 0, '0, mus, got);
        expect_mus("collision_new", mus, 32'h11_02_7E_02);

        // Reset in the middle of a sample.
        in_x = 8'h40; in_valid = 1'b1; out_ready = 1'b1;
        got = 0;
        while (!(out_valid && out_sel == 2'd1) && got < 20) begin got++; tick(); end
        in_valid = 1'b0;
        cen = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("midrst_valid", int'(out_valid), 0);
        chk("midrst_sel", int'(out_sel), 0);
        chk("midrst_mu", int'(out_mu), 0);
        chk("midrst_busy", int'(init_busy), 1);
        run_init(1'b0);
        run_sample(8'h40, 4'hF, 0, '0, mus, got);
        expect_mus("x40_after_reinit", mus, 32'h02020202);

        for (int c = 0; c < 3000; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_x      = AW'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            wr_en     = ($urandom_range(0, 3) == 0);
            wr_sel    = SW'($urandom);
            wr_addr   = AW'($urandom_range(0, 15));
            wr_data   = DW'($urandom);
            if (in_valid) in_x = AW'($urandom_range(0, 15));
            cen       = (c == 1500);
            tick();
        end
        cen = 1'b0; in_valid = 1'b0; wr_en = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
